cache_memory_assoc: RTL and testbench

Parametrised N-way set-associative cache storage array with tree pseudo-LRU replacement, word-granular write-on-hit, victim reporting on miss, and a post-reset invalidation sweep. It sits between the cache-controller FSM and the memory interface, replacing the direct-mapped single-way tag/data array. Requests use a valid/ready handshake, and responses arrive one cycle later.

---
 rtl/cache_memory_assoc_pkg.sv | 34 +++
 rtl/cache_memory_assoc_plru_tree.sv | 39 +++
 rtl/cache_memory_assoc.sv | 168 ++++++++++++++++
 tb/tb_cache_memory_assoc.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_memory_assoc_pkg.sv
// cache_pkg: shared op/state encodings and geometry helpers for the set-associative cache array
package cache_pkg;

   typedef enum logic [1:0] {
      OP_LOOKUP     = 2'b00,
      OP_FILL       = 2'b01,
      OP_WORD_WRITE = 2'b10
   } op_e;

   typedef enum logic [1:0] {
      ST_RESET = 2'b00,
      ST_INIT  = 2'b01,
      ST_READY = 2'b10
   } state_e;

   function automatic int log2(input int v);
      int r = 0;
      while ((1 << r) < v) r++;
      return r;
   endfunction

   function automatic int at_least_1(input int v);
      return v < 1 ? 1 : v;
   endfunction

   function automatic int num_sets(input int cache_bytes, input int block_bits, input int ways);
      return cache_bytes * 8 / block_bits / ways;
   endfunction

   function automatic int offset_w(input int block_bits, input int data_bits);
      return log2(block_bits / data_bits);
   endfunction

endpackage

// File: rtl/cache_memory_assoc_plru_tree.sv
// plru_tree: tree pseudo-LRU victim choice and MRU update for one set
module plru_tree
   import cache_pkg::*;
#(
   parameter int NUM_WAYS = 2
)(
   input  logic [at_least_1(NUM_WAYS-1)-1:0]     bits,
   input  logic [NUM_WAYS-1:0]                   valid,
   input  logic [at_least_1(log2(NUM_WAYS))-1:0] mru_way,
   output logic [at_least_1(log2(NUM_WAYS))-1:0] victim,
   output logic [at_least_1(NUM_WAYS-1)-1:0]     bits_upd
);

   localparam int WAY_W  = at_least_1(log2(NUM_WAYS));
   localparam int LEVELS = log2(NUM_WAYS);

   // walk the tree toward the LRU leaf; an invalid way always takes precedence, lowest index first
   always_comb begin
      int node;
      logic [WAY_W-1:0] plru_way;
      node = 1;
      for (int l = 0; l < LEVELS; l++) node = 2 * node + int'(bits[node-1]);
      plru_way = WAY_W'(node - NUM_WAYS);
      victim = plru_way;
      for (int w = NUM_WAYS - 1; w >= 0; w--) if (!valid[w]) victim = WAY_W'(w);
   end

   // point every node on the MRU way's path away from it
   always_comb begin
      int node;
      bits_upd = bits;
      node = 1;
      for (int l = LEVELS - 1; l >= 0; l--) begin
         bits_upd[node-1] = ~mru_way[l];
         node = 2 * node + int'(mru_way[l]);
      end
   end

endmodule

// File: rtl/cache_memory_assoc.sv
// cache_memory_assoc: N-way set-associative tag/data array with PLRU replacement and post-reset sweep
module cache_memory_assoc
   import cache_pkg::*;
#(
   parameter int ADDR_WIDTH = 28,
   parameter int DATA_WIDTH = 32,
   parameter int BLOCK_SIZE = 256,
   parameter int CACHE_SIZE = 65536,
   parameter int NUM_WAYS   = 2
)(
   input  logic                                  clk,
   input  logic                                  rst_n,
   input  logic                                  req_valid,
   output logic                                  req_ready,
   input  logic [1:0]                            op,
   input  logic [ADDR_WIDTH-1:0]                 addr,
   input  logic [BLOCK_SIZE-1:0]                 data_write,
   input  logic                                  dirty_write,
   input  logic [DATA_WIDTH-1:0]                 word_write,
   output logic                                  resp_valid,
   output logic                                  hit,
   output logic [at_least_1(log2(NUM_WAYS))-1:0] hit_way,
   output logic [BLOCK_SIZE-1:0]                 data_read,
   output logic                                  dirty_read,
   output logic                                  victim_valid,
   output logic [ADDR_WIDTH-1:0]                 victim_addr
);

   localparam int NUM_SETS = num_sets(CACHE_SIZE, BLOCK_SIZE, NUM_WAYS);
   localparam int OFFSET_W = offset_w(BLOCK_SIZE, DATA_WIDTH);
   localparam int INDEX_W  = log2(NUM_SETS);
   localparam int TAG_W    = ADDR_WIDTH - INDEX_W - OFFSET_W;
   localparam int WAY_W    = at_least_1(log2(NUM_WAYS));
   localparam int PLRU_W   = at_least_1(NUM_WAYS - 1);

   logic [BLOCK_SIZE-1:0] data_mem  [NUM_WAYS][NUM_SETS];
   logic [TAG_W-1:0]      tag_mem   [NUM_WAYS][NUM_SETS];
   logic [NUM_WAYS-1:0]   valid_mem [NUM_SETS];
   logic [NUM_WAYS-1:0]   dirty_mem [NUM_SETS];
   logic [PLRU_W-1:0]     plru_mem  [NUM_SETS];

   state_e                state;
   logic [INDEX_W-1:0]    init_set;
   logic [TAG_W-1:0]      req_tag;
   logic [INDEX_W-1:0]    req_idx;
   logic [OFFSET_W-1:0]   req_off;
   logic [NUM_WAYS-1:0]   set_valid;
   logic [NUM_WAYS-1:0]   match;
   logic [WAY_W-1:0]      hit_idx;
   logic [WAY_W-1:0]      victim;
   logic [WAY_W-1:0]      sel_way;
   logic [PLRU_W-1:0]     plru_upd;
   logic [BLOCK_SIZE-1:0] line_upd;
   logic [BLOCK_SIZE-1:0] new_line;
   logic                  hit_any;
   logic                  is_fill;
   logic                  is_ww;
   logic                  accept;
   logic                  wr_line;
   logic                  resp_valid_q;

   assign req_tag   = addr[ADDR_WIDTH-1 -: TAG_W];
   assign req_idx   = addr[OFFSET_W +: INDEX_W];
   assign req_off   = addr[OFFSET_W-1:0];
   assign set_valid = valid_mem[req_idx];
   assign is_fill   = op == OP_FILL;
   assign is_ww     = op == OP_WORD_WRITE;
   assign accept    = req_valid & req_ready & rst_n;
   assign hit_any   = |match;
   assign sel_way   = (hit_any && !is_fill) ? hit_idx : victim;
   assign wr_line   = is_fill | (is_ww & hit_any);
   assign new_line  = is_fill ? data_write : line_upd;

   // tag compare across the ways; lowest matching way wins should duplicates ever exist
   always_comb begin
      hit_idx = '0;
      match = '0;
      for (int w = NUM_WAYS - 1; w >= 0; w--) begin
         match[w] = set_valid[w] && tag_mem[w][req_idx] == req_tag;
         if (match[w]) hit_idx = WAY_W'(w);
      end
   end

   // selected line, with the addressed word merged in for a write hit
   always_comb begin
      line_upd = data_mem[sel_way][req_idx];
      if (is_ww && hit_any) line_upd[req_off*DATA_WIDTH +: DATA_WIDTH] = word_write;
   end

   plru_tree #(.NUM_WAYS(NUM_WAYS)) u_plru (
      .bits     (plru_mem[req_idx]),
      .valid    (set_valid),
      .mru_way  (sel_way),
      .victim   (victim),
      .bits_upd (plru_upd)
   );

   // control FSM: reset, one-set-per-cycle invalidation sweep, then accept requests
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_RESET;
         init_set <= '0;
         req_ready <= 1'b0;
      end else begin
         case (state)
            ST_RESET: state <= ST_INIT;
            ST_INIT: begin
               init_set <= init_set + 1'b1;
               if (init_set == INDEX_W'(NUM_SETS - 1)) begin
                  state <= ST_READY;
                  req_ready <= 1'b1;
               end
            end
            default: req_ready <= 1'b1;
         endcase
      end
   end

   // per-set metadata: cleared by the sweep, updated by accepted requests
   always_ff @(posedge clk) begin
      if (state == ST_INIT) begin
         valid_mem[init_set] <= '0;
         dirty_mem[init_set] <= '0;
         plru_mem[init_set] <= '0;
      end else if (accept) begin
         if (wr_line) begin
            valid_mem[req_idx][sel_way] <= 1'b1;
            dirty_mem[req_idx][sel_way] <= is_fill ? dirty_write : 1'b1;
         end
         if (is_fill | hit_any) plru_mem[req_idx] <= plru_upd;
      end
   end

   // line data and tags, written at the accepting edge so the next request sees them
   always_ff @(posedge clk) begin
      if (accept && wr_line) begin
         data_mem[sel_way][req_idx] <= new_line;
         if (is_fill) tag_mem[sel_way][req_idx] <= req_tag;
      end
   end

   // registered response, held between strobes
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         resp_valid_q <= 1'b0;
         hit <= 1'b0;
         hit_way <= '0;
         data_read <= '0;
         dirty_read <= 1'b0;
         victim_valid <= 1'b0;
         victim_addr <= '0;
      end else begin
         resp_valid_q <= accept;
         if (accept) begin
            hit <= is_fill | hit_any;
            hit_way <= sel_way;
            data_read <= new_line;
            dirty_read <= is_fill ? dirty_write : ((is_ww & hit_any) | dirty_mem[req_idx][sel_way]);
            victim_valid <= !(is_fill | hit_any) & set_valid[victim];
            victim_addr <= (is_fill | hit_any) ? '0 : {tag_mem[victim][req_idx], req_idx, OFFSET_W'(0)};
         end
      end
   end

   // a reset in the response cycle drops the response
   assign resp_valid = resp_valid_q & rst_n;

endmodule

// File: tb/tb_cache_memory_assoc.sv
// tb_cache_memory_assoc: directed requests checked against an LRU reference model of the cache
module tb_cache_memory_assoc;
   import cache_pkg::*;

   localparam int CACHE_SIZE = 131072;
   localparam int WAYS       = 2;
   localparam int NSETS      = CACHE_SIZE * 8 / 256 / WAYS;
   localparam int WPL        = 256 / 32;
   localparam logic [27:0] A = 28'h0004010;
   localparam logic [27:0] B = 28'h0008010;
   localparam logic [27:0] C = 28'h000C010;
   localparam logic [255:0] A_WW = 256'h00000000_00000000_DEADBEEF_00000000_00000000_00000000_00000000_00000011;

   typedef struct packed {
      logic         hit;
      logic         way;
      logic [255:0] data;
      logic         dirty;
      logic         vv;
      logic [27:0]  vaddr;
      logic         known;
      logic         lit;
      logic         l_hit;
      logic         l_way;
      logic         l_dirty;
      logic         l_vv;
      logic [27:0]  l_vaddr;
      logic         l_den;
      logic [255:0] l_data;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic         req_valid = 1'b0;
   logic         req_ready;
   logic [1:0]   op = 2'b00;
   logic [27:0]  addr = '0;
   logic [255:0] data_write = '0;
   logic         dirty_write = 1'b0;
   logic [31:0]  word_write = '0;
   logic         resp_valid;
   logic         hit;
   logic [0:0]   hit_way;
   logic [255:0] data_read;
   logic         dirty_read;
   logic         victim_valid;
   logic [27:0]  victim_addr;

   int           m_tag   [NSETS][WAYS];
   logic [255:0] m_data  [NSETS][WAYS];
   bit           m_valid [NSETS][WAYS];
   bit           m_dirty [NSETS][WAYS];
   longint       m_use   [NSETS][WAYS];
   longint       stamp;
   exp_t         exp_q[$];

   int   n_vec = 0;
   int   n_err = 0;
   int   rel = 0;
   int   idx = 0;
   logic acc = 1'b0;
   logic rst_seen = 1'b0;

   cache_memory_assoc #(.CACHE_SIZE(CACHE_SIZE), .NUM_WAYS(WAYS)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .op           (op),
      .addr         (addr),
      .data_write   (data_write),
      .dirty_write  (dirty_write),
      .word_write   (word_write),
      .resp_valid   (resp_valid),
      .hit          (hit),
      .hit_way      (hit_way),
      .data_read    (data_read),
      .dirty_read   (dirty_read),
      .victim_valid (victim_valid),
      .victim_addr  (victim_addr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] req);
      n_vec++;
      if (act !== req) begin
         n_err++;
         $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   task automatic model_reset();
      for (int s = 0; s < NSETS; s++)
         for (int k = 0; k < WAYS; k++) begin
            m_valid[s][k] = 0;
            m_dirty[s][k] = 0;
            m_use[s][k] = 0;
         end
      stamp = 0;
   endtask

   task automatic model_req(input logic [1:0] o, input logic [27:0] a, input logic [255:0] d,
                            input logic dw, input logic [31:0] wd, output exp_t e);
      int line, set, tag, off, hw, vic;
      line = int'(a) / WPL;
      set = line % NSETS;
      tag = line / NSETS;
      off = int'(a) % WPL;
      e = '0;
      hw = -1;
      vic = -1;
      for (int k = WAYS - 1; k >= 0; k--) begin
         if (m_valid[set][k] && m_tag[set][k] == tag) hw = k;
         if (!m_valid[set][k]) vic = k;
      end
      if (vic < 0) begin
         vic = 0;
         for (int k = 1; k < WAYS; k++) if (m_use[set][k] < m_use[set][vic]) vic = k;
      end
      stamp++;
      if (o == OP_FILL) begin
         m_valid[set][vic] = 1;
         m_tag[set][vic] = tag;
         m_data[set][vic] = d;
         m_dirty[set][vic] = dw;
         m_use[set][vic] = stamp;
         e.hit = 1;
         e.way = 1'(vic);
         e.data = d;
         e.dirty = dw;
         e.known = 1;
      end else if (hw >= 0) begin
         if (o == OP_WORD_WRITE) begin
            m_data[set][hw][off*32 +: 32] = wd;
            m_dirty[set][hw] = 1;
         end
         m_use[set][hw] = stamp;
         e.hit = 1;
         e.way = 1'(hw);
         e.data = m_data[set][hw];
         e.dirty = m_dirty[set][hw];
         e.known = 1;
      end else begin
         e.way = 1'(vic);
         e.vv = m_valid[set][vic];
         e.known = m_valid[set][vic];
         e.data = m_data[set][vic];
         e.dirty = m_dirty[set][vic];
         e.vaddr = 28'((m_tag[set][vic] * NSETS + set) * WPL);
      end
   endtask

   task automatic issue(input logic [1:0] o, input logic [27:0] a, input logic [255:0] d,
                        input logic dw, input logic [31:0] wd);
      exp_t e;
      @(negedge clk);
      model_req(o, a, d, dw, wd, e);
      exp_q.push_back(e);
      req_valid = 1'b1;
      op = o;
      addr = a;
      data_write = d;
      dirty_write = dw;
      word_write = wd;
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic pin(input logic h, input logic wy, input logic dr, input logic vv,
                      input logic [27:0] va, input logic den, input logic [255:0] dt);
      exp_t e;
      e = exp_q[exp_q.size()-1];
      e.lit = 1;
      e.l_hit = h;
      e.l_way = wy;
      e.l_dirty = dr;
      e.l_vv = vv;
      e.l_vaddr = va;
      e.l_den = den;
      e.l_data = dt;
      exp_q[exp_q.size()-1] = e;
   endtask

   // compare process: readiness from reset history, response against model and literal pins
   always begin
      exp_t e;
      @(posedge clk);
      acc = req_valid && rel > NSETS && rst_n;
      rst_seen = !rst_n;
      rel = rst_n ? rel + 1 : 0;
      @(negedge clk);
      chk("req_ready", 256'(req_ready), 256'(rel > NSETS));
      chk("resp_valid", 256'(resp_valid), 256'(acc && rst_n));
      if (rst_seen) begin
         chk("rst_hit", 256'(hit), 0);
         chk("rst_hit_way", 256'(hit_way), 0);
         chk("rst_data_read", data_read, 0);
         chk("rst_dirty_read", 256'(dirty_read), 0);
         chk("rst_victim_valid", 256'(victim_valid), 0);
         chk("rst_victim_addr", 256'(victim_addr), 0);
      end
      if (acc) begin
         if (idx >= exp_q.size()) begin
            n_vec++;
            n_err++;
            $display("FAIL resp_expectation: got response %0d, required none queued", idx);
         end else if (rst_n) begin
            e = exp_q[idx];
            chk("hit", 256'(hit), 256'(e.hit));
            chk("hit_way", 256'(hit_way), 256'(e.way));
            chk("dirty_read", 256'(dirty_read), 256'(e.dirty));
            if (e.known) chk("data_read", data_read, e.data);
            if (!e.hit) begin
               chk("victim_valid", 256'(victim_valid), 256'(e.vv));
               if (e.vv) chk("victim_addr", 256'(victim_addr), 256'(e.vaddr));
            end
            if (e.lit) begin
               chk("pin_hit", 256'(hit), 256'(e.l_hit));
               chk("pin_hit_way", 256'(hit_way), 256'(e.l_way));
               chk("pin_dirty_read", 256'(dirty_read), 256'(e.l_dirty));
               if (!e.l_hit) chk("pin_victim_valid", 256'(victim_valid), 256'(e.l_vv));
               if (!e.l_hit && e.l_vv) chk("pin_victim_addr", 256'(victim_addr), 256'(e.l_vaddr));
               if (e.l_den) chk("pin_data_read", data_read, e.l_data);
            end
         end
         idx++;
      end
   end

   initial begin
      exp_t e;
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (NSETS + 1) @(negedge clk);
      issue(OP_LOOKUP, A, '0, 0, 0);            pin(0, 0, 0, 0, '0, 0, '0);
      issue(OP_FILL, A, 256'h11, 0, 0);         pin(1, 0, 0, 0, '0, 1, 256'h11);
      issue(OP_LOOKUP, A, '0, 0, 0);            pin(1, 0, 0, 0, '0, 1, 256'h11);
      issue(OP_FILL, B, 256'h22, 1, 0);         pin(1, 1, 1, 0, '0, 1, 256'h22);
      issue(OP_LOOKUP, A, '0, 0, 0);            pin(1, 0, 0, 0, '0, 1, 256'h11);
      issue(OP_LOOKUP, C, '0, 0, 0);            pin(0, 1, 1, 1, B, 1, 256'h22);
      issue(OP_WORD_WRITE, A + 28'd5, '0, 0, 32'hDEADBEEF); pin(1, 0, 1, 0, '0, 1, A_WW);
      issue(OP_LOOKUP, A, '0, 0, 0);            pin(1, 0, 1, 0, '0, 1, A_WW);
      issue(OP_WORD_WRITE, C, '0, 0, 32'h12345678); pin(0, 1, 1, 1, B, 1, 256'h22);
      issue(OP_LOOKUP, C, '0, 0, 0);            pin(0, 1, 1, 1, B, 1, 256'h22);
      issue(OP_FILL, C, 256'h33, 0, 0);         pin(1, 1, 0, 0, '0, 1, 256'h33);
      issue(OP_LOOKUP, C, '0, 0, 0);            pin(1, 1, 0, 0, '0, 1, 256'h33);
      issue(OP_LOOKUP, B, '0, 0, 0);            pin(0, 0, 1, 1, A, 1, A_WW);
      issue(2'b11, A, '0, 0, 0);                pin(1, 0, 1, 0, '0, 1, A_WW);
      for (int i = 0; i < 6; i++) begin
         issue(OP_FILL, 28'(((i + 1) * NSETS + 5) * WPL + i), {8{32'(i * 7 + 1)}}, 1'(i), 0);
         issue(OP_LOOKUP, 28'((i * NSETS + 5) * WPL), '0, 0, 0);
         issue(OP_WORD_WRITE, 28'(((i + 1) * NSETS + 5) * WPL + 7 - i), '0, 0, 32'(i * 3 + 9));
      end
      @(negedge clk);
      model_req(OP_LOOKUP, A, '0, 0, 0, e);
      exp_q.push_back(e);
      req_valid = 1'b1;
      op = OP_LOOKUP;
      addr = A;
      @(posedge clk);
      #1 rst_n = 1'b0;
      req_valid = 1'b0;
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (101) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (NSETS + 1) @(negedge clk);
      issue(OP_LOOKUP, A, '0, 0, 0);            pin(0, 0, 0, 0, '0, 0, '0);
      repeat (3) @(negedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
